// File: rtl/qnna_wb_master.sv
// Wishbone B4 classic single-transfer master: takes a command, runs one bus cycle
// (ack, error or timeout), then holds a registered response until it is consumed.
module qnna_wb_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_timeout;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic [3:0]  r_sel;
    logic        r_cyc;
    logic [15:0] r_cnt;

    state_t      w_state_nxt;
    logic        w_cmd_ready_nxt;
    logic        w_busy_nxt;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic        w_rsp_err_nxt;
    logic        w_rsp_timeout_nxt;
    logic [31:0] w_adr_nxt;
    logic [31:0] w_dat_nxt;
    logic        w_we_nxt;
    logic [3:0]  w_sel_nxt;
    logic        w_cyc_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_tmo_hit;

    // A zero TIMEOUT_CYCLES lets a silent slave stall the bus forever.
    assign w_tmo_hit = (TIMEOUT_CYCLES != 16'd0) && (r_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_adr         <= 32'd0;
            r_dat         <= 32'd0;
            r_we          <= 1'b0;
            r_sel         <= 4'd0;
            r_cyc         <= 1'b0;
            r_cnt         <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_busy        <= w_busy_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_adr         <= w_adr_nxt;
            r_dat         <= w_dat_nxt;
            r_we          <= w_we_nxt;
            r_sel         <= w_sel_nxt;
            r_cyc         <= w_cyc_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_busy_nxt        = r_busy;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_adr_nxt         = r_adr;
        w_dat_nxt         = r_dat;
        w_we_nxt          = r_we;
        w_sel_nxt         = r_sel;
        w_cyc_nxt         = r_cyc;
        w_cnt_nxt         = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_adr_nxt       = cmd_addr;
                    w_dat_nxt       = cmd_wdata;
                    w_we_nxt        = cmd_we;
                    w_sel_nxt       = cmd_sel;
                    w_cyc_nxt       = 1'b1;
                    w_cnt_nxt       = 16'd0;
                    w_cmd_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_BUS;
                end
            end
            S_BUS: begin
                // err beats ack, and either beats a timeout landing on the same cycle.
                if (wbm_err_i) begin
                    w_cyc_nxt         = 1'b0;
                    w_rsp_rdata_nxt   = 32'd0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else if (wbm_ack_i) begin
                    w_cyc_nxt         = 1'b0;
                    w_rsp_rdata_nxt   = r_we ? 32'd0 : wbm_dat_i;
                    w_rsp_err_nxt     = 1'b0;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else if (w_tmo_hit) begin
                    w_cyc_nxt         = 1'b0;
                    w_rsp_rdata_nxt   = 32'd0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_stb_o   = r_cyc;
    assign wbm_cyc_o   = r_cyc;

endmodule
